// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared types and encodings for the multicycle MIPS controller (HALT exists only with CTRL_SINGLE_STEP_EN)
package mips_ctrl_pkg;
  localparam int ALU_W = 3;
  localparam int ST_W = 4;
`ifdef CTRL_SINGLE_STEP_EN
  typedef enum logic [ST_W-1:0] {
    FETCH, DECODE, R_EXEC, R_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, I_EXEC, I_WB, HALT
  } state_t;
`else
  typedef enum logic [ST_W-1:0] {
    FETCH, DECODE, R_EXEC, R_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, I_EXEC, I_WB
  } state_t;
`endif
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;
  localparam logic [1:0] SRCB_RT = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;
  localparam logic [1:0] PCS_ALU = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP = 2'd2;
endpackage

// File: rtl/mips_control_fsm_if.sv
// mips_control_fsm_if: controller <-> datapath bundle; step exists only with CTRL_SINGLE_STEP_EN
interface mips_control_fsm_if #(parameter int ALUSEL_W = 3, parameter int STATE_W = 4);
`ifdef CTRL_SINGLE_STEP_EN
  logic step;
`endif
  logic [5:0] opcode, func;
  logic zero;
  logic PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [ALUSEL_W-1:0] ALUSel;
  logic [STATE_W-1:0] state;
  logic illegal, instr_done;
  modport master (
`ifdef CTRL_SINGLE_STEP_EN
    input step,
`endif
    input opcode, func, zero,
    output PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA,
    output ALUSrcB, PCSource, ALUSel, state, illegal, instr_done
  );
  modport slave (
`ifdef CTRL_SINGLE_STEP_EN
    output step,
`endif
    output opcode, func, zero,
    input PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA,
    input ALUSrcB, PCSource, ALUSel, state, illegal, instr_done
  );
endinterface

// File: rtl/mips_alu_decode.sv
// mips_alu_decode: R-type funct field to ALU operation, with a flag for recognised functs
module mips_alu_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]       func,
  output logic [ALU_W-1:0] alu_sel,
  output logic             valid
);
  assign alu_sel = func == F_SUB ? ALU_SUB :
                   func == F_AND ? ALU_AND :
                   func == F_OR  ? ALU_OR  :
                   func == F_SLT ? ALU_SLT : ALU_ADD;
  assign valid = func inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
endmodule

// File: rtl/mips_control_fsm.sv
// mips_control_fsm: multicycle MIPS main controller; CTRL_SINGLE_STEP_EN adds step input and HALT state
module mips_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int ALUSEL_W = ALU_W,
  parameter int STATE_W = ST_W
) (
  input logic clk,
  input logic rst,
  mips_control_fsm_if.master bus
);
`ifdef CTRL_SINGLE_STEP_EN
  localparam state_t IDLE = HALT;
`else
  localparam state_t IDLE = FETCH;
`endif
  state_t st, nxt;
  logic [ALU_W-1:0] r_alu, alu;
  logic r_ok, pc_en, iord, mem_rd, mem_wr, m2r, ir_wr, reg_wr, reg_dst, src_a, ill, done;
  logic [1:0] src_b, pc_src;
  mips_alu_decode u_dec (.func(bus.func), .alu_sel(r_alu), .valid(r_ok));
  always_ff @(posedge clk) st <= rst ? nxt : IDLE;
  always_comb begin
    nxt = IDLE;
    pc_en = 1'b0;
    iord = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    m2r = 1'b0;
    ir_wr = 1'b0;
    reg_wr = 1'b0;
    reg_dst = 1'b0;
    src_a = 1'b0;
    src_b = SRCB_RT;
    pc_src = PCS_ALU;
    alu = ALU_ADD;
    ill = 1'b0;
    done = 1'b0;
    case (st)
      FETCH: begin
        mem_rd = 1'b1;
        ir_wr = 1'b1;
        src_b = SRCB_ONE;
        pc_en = 1'b1;
        nxt = DECODE;
      end
      DECODE: begin
        src_b = SRCB_IMM;
        nxt = bus.opcode == OP_RTYPE ? R_EXEC :
              bus.opcode inside {OP_LW, OP_SW} ? MEM_ADDR :
              bus.opcode inside {OP_BEQ, OP_BNE} ? BRANCH :
              bus.opcode == OP_J ? JUMP :
              bus.opcode inside {OP_ADDI, OP_SLTI} ? I_EXEC : IDLE;
        ill = nxt == IDLE;
        done = ill;
      end
      R_EXEC: begin
        src_a = 1'b1;
        alu = r_alu;
        nxt = r_ok ? R_WB : IDLE;
        ill = !r_ok;
        done = !r_ok;
      end
      R_WB: begin
        reg_wr = 1'b1;
        reg_dst = 1'b1;
        done = 1'b1;
      end
      MEM_ADDR: begin
        src_a = 1'b1;
        src_b = SRCB_IMM;
        nxt = bus.opcode == OP_SW ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        iord = 1'b1;
        mem_rd = 1'b1;
        nxt = MEM_WB;
      end
      MEM_WB: begin
        reg_wr = 1'b1;
        m2r = 1'b1;
        done = 1'b1;
      end
      MEM_WRITE: begin
        iord = 1'b1;
        mem_wr = 1'b1;
        done = 1'b1;
      end
      // the branch target was precomputed into ALUOut during DECODE
      BRANCH: begin
        src_a = 1'b1;
        alu = ALU_SUB;
        pc_src = PCS_ALUOUT;
        pc_en = bus.opcode == OP_BNE ? !bus.zero : bus.zero;
        done = 1'b1;
      end
      JUMP: begin
        pc_src = PCS_JUMP;
        pc_en = 1'b1;
        done = 1'b1;
      end
      I_EXEC: begin
        src_a = 1'b1;
        src_b = SRCB_IMM;
        alu = bus.opcode == OP_SLTI ? ALU_SLT : ALU_ADD;
        nxt = I_WB;
      end
      I_WB: begin
        reg_wr = 1'b1;
        done = 1'b1;
      end
`ifdef CTRL_SINGLE_STEP_EN
      HALT: nxt = bus.step ? FETCH : HALT;
`endif
      default: ;
    endcase
  end
  assign bus.PCEn = rst & pc_en;
  assign bus.MemRead = rst & mem_rd;
  assign bus.MemWrite = rst & mem_wr;
  assign bus.IRWrite = rst & ir_wr;
  assign bus.RegWrite = rst & reg_wr;
  assign bus.illegal = rst & ill;
  assign bus.instr_done = rst & done;
  assign bus.IorD = iord;
  assign bus.MemtoReg = m2r;
  assign bus.RegDst = reg_dst;
  assign bus.ALUSrcA = src_a;
  assign bus.ALUSrcB = src_b;
  assign bus.PCSource = pc_src;
  assign bus.ALUSel = ALUSEL_W'(alu);
  assign bus.state = STATE_W'(st);
endmodule

// File: tb/tb_mips_control_fsm.sv
// tb_mips_control_fsm: random instruction stream checked cycle by cycle against a per-instruction model
module tb_mips_control_fsm;
  import mips_ctrl_pkg::*;
  typedef struct packed {
    logic pcen, iord, mrd, mwr, m2r, irw, rw, rdst, srca;
    logic [1:0] srcb, pcs;
    logic [2:0] alu;
    logic ill, done;
    logic [3:0] st;
  } ov_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_bad = 0;
  mips_control_fsm_if bus ();
  mips_control_fsm dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic ov_t obs();
    ov_t o;
    o = {bus.PCEn, bus.IorD, bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.IRWrite, bus.RegWrite,
         bus.RegDst, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALUSel, bus.illegal, bus.instr_done, bus.state};
    return o;
  endfunction
  function automatic logic [6:0] enables();
    return {bus.PCEn, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.illegal, bus.instr_done};
  endfunction
  function automatic bit legal_op(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b001000, 6'b001010};
  endfunction
  function automatic bit legal_fn(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction
  function automatic logic [2:0] fn_alu(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction
  function automatic int instr_len(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return legal_fn(fn) ? 4 : 3;
      6'b100011: return 5;
      6'b101011, 6'b001000, 6'b001010: return 4;
      6'b000100, 6'b000101, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction
  function automatic ov_t model(input int k, input logic [5:0] op, input logic [5:0] fn, input logic z);
    ov_t o;
    o = '0;
    o.alu = 3'b010;
    if (k == 0) begin
      o.mrd = 1; o.irw = 1; o.srcb = 2'd1; o.pcen = 1; o.st = FETCH;
      return o;
    end
    if (k == 1) begin
      o.srcb = 2'd2; o.st = DECODE; o.ill = !legal_op(op); o.done = o.ill;
      return o;
    end
    case (op)
      6'b000000:
        if (k == 2) begin
          o.srca = 1; o.alu = fn_alu(fn); o.ill = !legal_fn(fn); o.done = o.ill; o.st = R_EXEC;
        end else begin
          o.rw = 1; o.rdst = 1; o.done = 1; o.st = R_WB;
        end
      6'b100011, 6'b101011:
        if (k == 2) begin
          o.srca = 1; o.srcb = 2'd2; o.st = MEM_ADDR;
        end else if (op == 6'b101011) begin
          o.iord = 1; o.mwr = 1; o.done = 1; o.st = MEM_WRITE;
        end else if (k == 3) begin
          o.iord = 1; o.mrd = 1; o.st = MEM_READ;
        end else begin
          o.rw = 1; o.m2r = 1; o.done = 1; o.st = MEM_WB;
        end
      6'b000100, 6'b000101: begin
        o.srca = 1; o.alu = 3'b110; o.pcs = 2'd1; o.done = 1; o.st = BRANCH;
        o.pcen = op == 6'b000100 ? z : !z;
      end
      6'b000010: begin
        o.pcs = 2'd2; o.pcen = 1; o.done = 1; o.st = JUMP;
      end
      6'b001000, 6'b001010:
        if (k == 2) begin
          o.srca = 1; o.srcb = 2'd2; o.alu = op == 6'b001010 ? 3'b111 : 3'b010; o.st = I_EXEC;
        end else begin
          o.rw = 1; o.done = 1; o.st = I_WB;
        end
      default: ;
    endcase
    return o;
  endfunction
`ifdef CTRL_SINGLE_STEP_EN
  task automatic halt_cycle(input logic s);
    ov_t e;
    e = '0;
    e.alu = 3'b010;
    e.st = HALT;
    bus.step = s;
    #1 chk($sformatf("halt_step%0d", s), obs(), e);
    @(negedge clk);
  endtask
`endif
  // zf < 0 draws zero randomly each cycle; n < 0 runs the whole instruction
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zf, input int n);
    int len;
    len = n < 0 ? instr_len(op, fn) : n;
`ifdef CTRL_SINGLE_STEP_EN
    halt_cycle(1'b1);
`endif
    for (int k = 0; k < len; k++) begin
`ifdef CTRL_SINGLE_STEP_EN
      bus.step = 1'b0;
`endif
      bus.opcode = op;
      bus.func = fn;
      bus.zero = zf < 0 ? 1'($urandom) : 1'(zf);
      #1 chk($sformatf("op%b_fn%b_k%0d", op, fn, k), obs(), model(k, op, fn, bus.zero));
      @(negedge clk);
    end
  endtask
  initial begin
    logic [5:0] ops [8];
    logic [5:0] fns [5];
    logic [5:0] op, fn;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b001000, 6'b001010};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    bus.opcode = 6'b100011;
    bus.func = 6'b0;
    bus.zero = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
    bus.step = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("reset_enables", 32'(enables()), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    run_instr(6'b100011, 6'b0, -1, -1);
    run_instr(6'b000000, 6'b100010, -1, -1);
    run_instr(6'b000100, 6'b0, 1, -1);
    run_instr(6'b000100, 6'b0, 0, -1);
    run_instr(6'b000101, 6'b0, 1, -1);
    run_instr(6'b000101, 6'b0, 0, -1);
    run_instr(6'b000010, 6'b0, -1, -1);
    run_instr(6'b111111, 6'b0, -1, -1);
    run_instr(6'b000000, 6'b111111, -1, -1);
    run_instr(6'b101011, 6'b0, -1, -1);
    run_instr(6'b001010, 6'b0, -1, -1);
    run_instr(6'b100011, 6'b0, -1, 3);
    rst = 1'b0;
    #1 chk("midreset_enables", 32'(enables()), 32'd0);
    @(negedge clk);
    #1 chk("midreset_enables2", 32'(enables()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_instr(6'b000000, 6'b100101, -1, -1);
`ifdef CTRL_SINGLE_STEP_EN
    for (int i = 0; i < 3; i++) halt_cycle(1'b0);
    run_instr(6'b001000, 6'b0, -1, -1);
    for (int i = 0; i < 3; i++) halt_cycle(1'b0);
`endif
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9) > 7 ? 6'($urandom) : ops[$urandom_range(0, 7)];
      fn = $urandom_range(0, 5) > 4 ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr(op, fn, -1, -1);
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
